dram_rd_arbiter: RTL and testbench

Shares the single DRAM read-command port (kick/busy/read_num/read_addr) between two streaming clients, e.g. the UDP send path and a second DRAM consumer. Each client sees a private kick/busy interface with the same semantics as the raw port. The arbiter latches each client's request, grants the port to one owner at a time, and sequences the kick/busy handshake, including a busy-start timeout with re-kick. It exports the current owner so the read-data buffer stream (buf_we/buf_dout) is routed to the right client downstream.

---
 rtl/dram_rd_arbiter_if.sv | 33 +++
 rtl/dram_rd_arbiter.sv | 170 +++++++++++++++++
 tb/tb_dram_rd_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_rd_arbiter_if.sv
// Bundle of the two client request ports and the shared DRAM read-command port.
// slave = arbiter side, master = clients plus DRAM reader side.
interface dram_rd_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned NUM_WIDTH  = 32
);
    logic [1:0]            rq_kick;
    logic [NUM_WIDTH-1:0]  rq_num0;
    logic [NUM_WIDTH-1:0]  rq_num1;
    logic [ADDR_WIDTH-1:0] rq_addr0;
    logic [ADDR_WIDTH-1:0] rq_addr1;
    logic [1:0]            rq_busy;
    logic                  kick;
    logic                  busy;
    logic [NUM_WIDTH-1:0]  read_num;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic                  owner;
    logic                  owner_valid;
    logic [1:0]            err_kick;
    logic [7:0]            retry_cnt;

    modport slave (
        input  rq_kick, rq_num0, rq_num1, rq_addr0, rq_addr1, busy,
        output rq_busy, kick, read_num, read_addr, owner, owner_valid,
               err_kick, retry_cnt
    );

    modport master (
        output rq_kick, rq_num0, rq_num1, rq_addr0, rq_addr1, busy,
        input  rq_busy, kick, read_num, read_addr, owner, owner_valid,
               err_kick, retry_cnt
    );
endinterface

// File: rtl/dram_rd_arbiter.sv
// Two-client arbiter for the DRAM read-command port: request latching, kick/busy sequencing, busy-start timeout re-kick.
// Define DRAM_ARB_FIXED_PRIO_EN for fixed priority (client 0 wins ties); default is round-robin.
module dram_rd_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned NUM_WIDTH    = 32,
    parameter int unsigned BUSY_TIMEOUT = 1024
) (
    input logic              clk,
    input logic              rst,
    dram_rd_arbiter_if.slave bus
);
    localparam int unsigned      CNT_W    = $clog2(BUSY_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_RUN,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            pend_q, pend_d;
    logic [NUM_WIDTH-1:0]  slot_num_q [2];
    logic [NUM_WIDTH-1:0]  slot_num_d [2];
    logic [ADDR_WIDTH-1:0] slot_addr_q [2];
    logic [ADDR_WIDTH-1:0] slot_addr_d [2];
    logic                  kick_q, kick_d;
    logic [NUM_WIDTH-1:0]  read_num_q, read_num_d;
    logic [ADDR_WIDTH-1:0] read_addr_q, read_addr_d;
    logic                  owner_q, owner_d;
    logic                  owner_valid_q, owner_valid_d;
    logic [1:0]            err_kick_q, err_kick_d;
    logic [7:0]            retry_cnt_q, retry_cnt_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic                  win;

`ifdef DRAM_ARB_FIXED_PRIO_EN
    always_comb begin
        win = ~pend_q[0];
    end
`else
    logic last_owner_q, last_owner_d;

    // On a tie the client that was not served last wins.
    always_comb begin
        win          = (&pend_q) ? ~last_owner_q : ~pend_q[0];
        last_owner_d = (state_q == S_DONE) ? owner_q : last_owner_q;
    end

    always_ff @(posedge clk) begin
        if (rst) last_owner_q <= 1'b1;
        else     last_owner_q <= last_owner_d;
    end
`endif

    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        slot_num_d    = slot_num_q;
        slot_addr_d   = slot_addr_q;
        kick_d        = 1'b0;
        read_num_d    = read_num_q;
        read_addr_d   = read_addr_q;
        owner_d       = owner_q;
        owner_valid_d = owner_valid_q;
        err_kick_d    = err_kick_q;
        retry_cnt_d   = retry_cnt_q;
        wait_cnt_d    = wait_cnt_q;

        if (bus.rq_kick[0]) begin
            if (pend_q[0]) begin
                err_kick_d[0] = 1'b1;
            end else begin
                pend_d[0]      = 1'b1;
                slot_num_d[0]  = bus.rq_num0;
                slot_addr_d[0] = bus.rq_addr0;
            end
        end
        if (bus.rq_kick[1]) begin
            if (pend_q[1]) begin
                err_kick_d[1] = 1'b1;
            end else begin
                pend_d[1]      = 1'b1;
                slot_num_d[1]  = bus.rq_num1;
                slot_addr_d[1] = bus.rq_addr1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (|pend_q) begin
                    owner_d       = win;
                    read_num_d    = slot_num_q[win];
                    read_addr_d   = slot_addr_q[win];
                    owner_valid_d = 1'b1;
                    // Zero-length requests never reach the DRAM reader.
                    kick_d        = (slot_num_q[win] != '0);
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = (read_num_q == '0) ? S_DONE : S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (bus.busy) begin
                    state_d = S_RUN;
                end else if (wait_cnt_q == CNT_LAST) begin
                    state_d = S_ISSUE;
                    kick_d  = 1'b1;
                    if (retry_cnt_q != '1) retry_cnt_d = retry_cnt_q + 8'd1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (!bus.busy) state_d = S_DONE;
            end
            S_DONE: begin
                pend_d[owner_q] = 1'b0;
                owner_valid_d   = 1'b0;
                state_d         = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pend_q        <= '0;
            slot_num_q    <= '{default: '0};
            slot_addr_q   <= '{default: '0};
            kick_q        <= 1'b0;
            read_num_q    <= '0;
            read_addr_q   <= '0;
            owner_q       <= 1'b0;
            owner_valid_q <= 1'b0;
            err_kick_q    <= '0;
            retry_cnt_q   <= '0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            slot_num_q    <= slot_num_d;
            slot_addr_q   <= slot_addr_d;
            kick_q        <= kick_d;
            read_num_q    <= read_num_d;
            read_addr_q   <= read_addr_d;
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
            err_kick_q    <= err_kick_d;
            retry_cnt_q   <= retry_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    always_comb begin
        bus.rq_busy     = pend_q;
        bus.kick        = kick_q;
        bus.read_num    = read_num_q;
        bus.read_addr   = read_addr_q;
        bus.owner       = owner_q;
        bus.owner_valid = owner_valid_q;
        bus.err_kick    = err_kick_q;
        bus.retry_cnt   = retry_cnt_q;
    end
endmodule

// File: tb/tb_dram_rd_arbiter.sv
// Bench for dram_rd_arbiter: directed scenarios plus random traffic against a transaction-timeline reference model.
module tb_dram_rd_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned NW = 32;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dram_rd_arbiter_if #(.ADDR_WIDTH(AW), .NUM_WIDTH(NW)) bus ();

    dram_rd_arbiter #(
        .ADDR_WIDTH  (AW),
        .NUM_WIDTH   (NW),
        .BUSY_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;
    int unsigned cyc   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Reference model: requests, slots and the current grant as a timeline
    // (grant start, DONE cycle, busy window chosen by the bench's DRAM reader).
    bit [1:0]        m_pend, m_err;
    logic [NW-1:0]   m_snum [2];
    logic [AW-1:0]   m_saddr [2];
    bit              m_last, m_act, m_own;
    logic [NW-1:0]   m_num;
    logic [AW-1:0]   m_addr;
    int unsigned     m_gs, m_ge, m_d, m_h;
    bit              exp_kick, exp_busy;
    bit              model_on;
    bit              fix_dh;
    int unsigned     fix_d, fix_h;

    task automatic model_reset();
        m_pend = '0; m_err = '0; m_last = 1'b1; m_act = 1'b0; m_own = 1'b0;
        m_num = '0; m_addr = '0; m_snum = '{default: '0}; m_saddr = '{default: '0};
        exp_kick = 1'b0; exp_busy = 1'b0;
    endtask

    function automatic bit pick(input bit [1:0] p);
`ifdef DRAM_ARB_FIXED_PRIO_EN
        return p[0] ? 1'b0 : 1'b1;
`else
        if (p == 2'b11) return ~m_last;
        return p[0] ? 1'b0 : 1'b1;
`endif
    endfunction

    task automatic model_edge();
        int unsigned t = cyc;
        int unsigned n = cyc + 1;
        bit [1:0] old = m_pend;
        if (rst) begin
            model_reset();
            return;
        end
        if (bus.rq_kick[0]) begin
            if (old[0]) m_err[0] = 1'b1;
            else begin m_pend[0] = 1'b1; m_snum[0] = bus.rq_num0; m_saddr[0] = bus.rq_addr0; end
        end
        if (bus.rq_kick[1]) begin
            if (old[1]) m_err[1] = 1'b1;
            else begin m_pend[1] = 1'b1; m_snum[1] = bus.rq_num1; m_saddr[1] = bus.rq_addr1; end
        end
        if (!m_act) begin
            if (old != 2'b00) begin
                m_own  = pick(old);
                m_num  = m_snum[m_own];
                m_addr = m_saddr[m_own];
                m_act  = 1'b1;
                m_gs   = t + 1;
                m_d    = fix_dh ? fix_d : $urandom_range(1, 5);
                m_h    = fix_dh ? fix_h : $urandom_range(1, 6);
                m_ge   = (m_num == 0) ? m_gs + 1 : m_gs + m_d + m_h + 1;
            end
        end else if (t == m_ge) begin
            m_pend[m_own] = 1'b0;
            m_last        = m_own;
            m_act         = 1'b0;
        end
        exp_kick = m_act && (n == m_gs) && (m_num != 0);
        exp_busy = m_act && (m_num != 0) && (n >= m_gs + m_d) && (n < m_gs + m_d + m_h);
    endtask

    task automatic compare_all();
        check_eq("rq_busy",     bus.rq_busy,     m_pend);
        check_eq("owner_valid", bus.owner_valid, m_act);
        check_eq("kick",        bus.kick,        exp_kick);
        check_eq("owner",       bus.owner,       m_own);
        check_eq("read_num",    bus.read_num,    m_num);
        check_eq("read_addr",   bus.read_addr,   m_addr);
        check_eq("err_kick",    bus.err_kick,    m_err);
        check_eq("retry_cnt",   bus.retry_cnt,   0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (model_on) model_edge();
        cyc++;
        @(negedge clk);
        if (model_on) begin
            compare_all();
            bus.busy = exp_busy;
        end
        bus.rq_kick = '0;
    endtask

    task automatic kick_client(input int unsigned i, input logic [NW-1:0] n, input logic [AW-1:0] a);
        bus.rq_kick[i] = 1'b1;
        if (i == 0) begin bus.rq_num0 = n; bus.rq_addr0 = a; end
        else        begin bus.rq_num1 = n; bus.rq_addr1 = a; end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int unsigned budget);
        for (int unsigned i = 0; i < budget && (bus.rq_busy != 2'b00 || bus.owner_valid); i++) tick();
        check_eq(tag, bus.rq_busy, 2'b00);
    endtask

    task automatic wait_kick(input int unsigned budget);
        for (int unsigned i = 0; i < budget && !bus.kick; i++) tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned t0, nk, last_k;
        rst = 1'b1;
        bus.rq_kick = '0; bus.rq_num0 = '0; bus.rq_num1 = '0;
        bus.rq_addr0 = '0; bus.rq_addr1 = '0; bus.busy = 1'b0;
        fix_dh = 1'b0; fix_d = 1; fix_h = 1;
        model_reset();
        model_on = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_kick",        bus.kick,        0);
        check_eq("rst_owner_valid", bus.owner_valid, 0);
        check_eq("rst_rq_busy",     bus.rq_busy,     0);
        check_eq("rst_read_num",    bus.read_num,    0);

        // Single request, busy high for 10 cycles from 3 cycles after the client kick
        fix_dh = 1'b1; fix_d = 1; fix_h = 10;
        t0 = cyc;
        kick_client(0, 256, 32'h1000);
        tick();
        wait_kick(8);
        check_eq("t1_kick_lat",  cyc - t0,      2);
        check_eq("t1_read_num",  bus.read_num,  256);
        check_eq("t1_read_addr", bus.read_addr, 32'h1000);
        for (int unsigned i = 0; i < 30 && bus.rq_busy[0]; i++) tick();
        check_eq("t1_rqbusy_fall", cyc - t0, 15);
        fix_dh = 1'b0;
        wait_idle("t1_idle", 10);

        // Simultaneous kicks, four rounds
        do_reset();
        for (int unsigned r = 0; r < 4; r++) begin
            kick_client(0, $urandom_range(1, 64), $urandom);
            kick_client(1, $urandom_range(1, 64), $urandom);
            tick();
            for (int unsigned g = 0; g < 2; g++) begin
                wait_kick(40);
                check_eq("t2_grant", bus.owner, g);
                for (int unsigned i = 0; i < 40 && bus.owner_valid; i++) tick();
            end
            wait_idle("t2_idle", 20);
        end

        // Client 1 kicks while client 0 is in RUN
        fix_dh = 1'b1; fix_d = 1; fix_h = 6;
        kick_client(0, 8, 32'h1000);
        tick();
        for (int unsigned i = 0; i < 20 && !bus.busy; i++) tick();
        tick();
        kick_client(1, 16, 32'h2000);
        tick();
        for (int unsigned i = 0; i < 40 && bus.owner_valid; i++) begin
            check_eq("t3_hold_addr", bus.read_addr, 32'h1000);
            tick();
        end
        wait_kick(10);
        check_eq("t3_next_owner", bus.owner,     1);
        check_eq("t3_next_addr",  bus.read_addr, 32'h2000);
        fix_dh = 1'b0;
        wait_idle("t3_idle", 40);

        // Re-kick while busy, then a zero-length request
        kick_client(0, 4, 32'h3000);
        tick();
        kick_client(0, 9, 32'h4444);
        tick();
        check_eq("t4_err0", bus.err_kick, 2'b01);
        wait_kick(10);
        check_eq("t4_addr_kept", bus.read_addr, 32'h3000);
        wait_idle("t4_idle", 40);
        check_eq("t4_err_sticky", bus.err_kick, 2'b01);
        t0 = cyc;
        nk = 0;
        kick_client(0, 0, 32'h5000);
        tick();
        for (int unsigned i = 0; i < 20 && bus.rq_busy[0]; i++) begin
            if (bus.kick) nk++;
            tick();
        end
        check_eq("t4_num0_span",  cyc - t0, 4);
        check_eq("t4_num0_kicks", nk,       0);

        // Reset during RUN
        do_reset();
        fix_dh = 1'b1; fix_d = 1; fix_h = 20;
        kick_client(1, 33, 32'h7700);
        tick();
        for (int unsigned i = 0; i < 20 && !bus.busy; i++) tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t5_kick",        bus.kick,        0);
        check_eq("t5_owner_valid", bus.owner_valid, 0);
        check_eq("t5_rq_busy",     bus.rq_busy,     0);
        check_eq("t5_read_addr",   bus.read_addr,   0);
        check_eq("t5_owner",       bus.owner,       0);
        fix_dh = 1'b0;
        for (int unsigned i = 0; i < 10; i++) tick();

        // Busy never rises: periodic re-kicks and retry_cnt saturation
        model_on = 1'b0;
        bus.busy = 1'b0;
        t0 = cyc;
        nk = 0;
        last_k = 0;
        kick_client(0, 7, 32'h6000);
        for (int unsigned i = 0; i < 5000 && nk < 258; i++) begin
            tick();
            if (bus.kick) begin
                nk++;
                if (nk == 1) check_eq("t6_first_kick", cyc - t0, 2);
                else if (nk <= 4) begin
                    check_eq("t6_interval", cyc - last_k, TO + 1);
                    check_eq("t6_retry",    bus.retry_cnt, nk - 1);
                end
                last_k = cyc;
            end
        end
        check_eq("t6_kick_count", nk,            258);
        check_eq("t6_retry_sat",  bus.retry_cnt, 255);
        bus.busy = 1'b1;
        tick(); tick(); tick();
        bus.busy = 1'b0;
        for (int unsigned i = 0; i < 10 && bus.rq_busy[0]; i++) tick();
        check_eq("t6_complete",   bus.rq_busy,   2'b00);
        check_eq("t6_retry_hold", bus.retry_cnt, 255);
        model_reset();
        model_on = 1'b1;
        do_reset();

        // Random traffic
        for (int unsigned i = 0; i < 1500; i++) begin
            for (int unsigned c = 0; c < 2; c++) begin
                if ($urandom_range(0, 5) == 0)
                    kick_client(c, ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 1000), $urandom);
            end
            tick();
        end
        wait_idle("rand_drain", 200);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
